// File: rtl/logic_gate_pkg.sv
// Shared opcode encoding for the bitwise gate pipeline.
package logic_gate_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND     = 3'd0;
    localparam logic [OPW-1:0] OP_OR      = 3'd1;
    localparam logic [OPW-1:0] OP_NOTB    = 3'd2;
    localparam logic [OPW-1:0] OP_NAND    = 3'd3;
    localparam logic [OPW-1:0] OP_NOR     = 3'd4;
    localparam logic [OPW-1:0] OP_XOR     = 3'd5;
    localparam logic [OPW-1:0] OP_XNOR    = 3'd6;
    localparam logic [OPW-1:0] OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/logic_gate_fn.sv
// Combinational bitwise function unit with result flags.
// An illegal opcode yields a zero result with the error flag set.
module logic_gate_fn
    import logic_gate_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [W-1:0]   y,
    output logic           zero,
    output logic           ones,
    output logic           par,
    output logic           err
);

    // Select the function, then derive flags from that same result.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTB: y = ~b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: err = 1'b1;
        endcase
        zero = (y == '0);
        ones = &y;
        par  = ^y;
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipeline around logic_gate_fn.
// S1 captures operands, S2 holds the computed result and flags.
// in_ready depends combinationally on out_ready so a full pipe can
// still accept when the consumer drains in the same cycle.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [OPW-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y,
    output logic           out_zero,
    output logic           out_ones,
    output logic           out_par,
    output logic           out_err,
    output logic [CW-1:0]  err_cnt
);

    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [OPW-1:0] s1_op;
    logic           s2_valid;

    logic           s1_load;
    logic           s2_load;

    logic [W-1:0]   fn_y;
    logic           fn_zero;
    logic           fn_ones;
    logic           fn_par;
    logic           fn_err;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    logic_gate_fn #(.W(W)) u_fn (
        .a    (s1_a),
        .b    (s1_b),
        .op   (s1_op),
        .y    (fn_y),
        .zero (fn_zero),
        .ones (fn_ones),
        .par  (fn_par),
        .err  (fn_err)
    );

    // S1 occupancy: fill on accept, empty when moved on without refill.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 operand capture on acceptance.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; s1_valid qualifies them, which keeps the datapath lean.
        if (s1_load) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_op <= in_op;
        end
    end

    // S2 result register: load from S1, clear valid once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_y    <= '0;
            out_zero <= 1'b0;
            out_ones <= 1'b0;
            out_par  <= 1'b0;
            out_err  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            out_y    <= fn_y;
            out_zero <= fn_zero;
            out_ones <= fn_ones;
            out_par  <= fn_par;
            out_err  <= fn_err;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Saturating count of accepted illegal opcodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (s1_load && (in_op == OP_ILLEGAL) && (err_cnt != {CW{1'b1}})) begin
            err_cnt <= err_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: directed vector table,
// backpressure, saturation and reset sequences, then random traffic.
module tb_logic_gate_pipe;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          out_zero;
    logic          out_ones;
    logic          out_par;
    logic          out_err;
    logic [CW-1:0] err_cnt;

    logic_gate_pipe #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         zero;
        logic         ones;
        logic         par;
        logic         err;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          exp_q[$];
    logic [CW-1:0] cnt_m;
    logic          held;
    logic [11:0]   held_val;
    logic          chk_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Independent reference of the gate functions and flags.
    function automatic vec_t ref_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t r;
        r.op  = op;
        r.a   = a;
        r.b   = b;
        r.err = 1'b0;
        case (op)
            3'd0: r.y = a & b;
            3'd1: r.y = a | b;
            3'd2: r.y = ~b;
            3'd3: r.y = ~(a & b);
            3'd4: r.y = ~(a | b);
            3'd5: r.y = a ^ b;
            3'd6: r.y = ~(a ^ b);
            default: begin
                r.y   = '0;
                r.err = 1'b1;
            end
        endcase
        r.zero = (r.y == '0);
        r.ones = (r.y == '1);
        r.par  = ^r.y;
        return r;
    endfunction

    // One clock cycle: drive inputs, observe at the falling edge, score, advance.
    task automatic cycle(input logic v, input vec_t t, input logic rdy, output logic acc);
        logic dlv;
        exp_t e;
        in_valid  = v;
        in_op     = t.op;
        in_a      = t.a;
        in_b      = t.b;
        out_ready = rdy;
        @(negedge clk);
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        check("err_cnt", 32'(err_cnt), 32'(cnt_m));
        if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({out_err, out_par, out_ones, out_zero, out_y}), 32'(held_val));
        end
        held     = out_valid && !out_ready;
        held_val = {out_err, out_par, out_ones, out_zero, out_y};
        if (dlv) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_y", 32'(out_y), 32'(e.v.y));
                check("out_flags", 32'({out_zero, out_ones, out_par, out_err}),
                      32'({e.v.zero, e.v.ones, e.v.par, e.v.err}));
                if (chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
            end
        end
        if (acc) begin
            exp_q.push_back('{v: t, acc_cyc: cyc});
            if (t.op == 3'd7 && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + CW'(1);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];
    vec_t bp[4];
    vec_t idle;
    vec_t item;
    logic acc;
    int   idx;
    int   sent;
    int   guard;

    initial begin
        // Directed table: hand-computed expected results.
        tbl[0]  = '{op: 3'd0, a: 8'hC3, b: 8'hA5, y: 8'h81, zero: 0, ones: 0, par: 0, err: 0};
        tbl[1]  = '{op: 3'd1, a: 8'hC3, b: 8'hA5, y: 8'hE7, zero: 0, ones: 0, par: 0, err: 0};
        tbl[2]  = '{op: 3'd2, a: 8'hC3, b: 8'hA5, y: 8'h5A, zero: 0, ones: 0, par: 0, err: 0};
        tbl[3]  = '{op: 3'd3, a: 8'hC3, b: 8'hA5, y: 8'h7E, zero: 0, ones: 0, par: 0, err: 0};
        tbl[4]  = '{op: 3'd4, a: 8'hC3, b: 8'hA5, y: 8'h18, zero: 0, ones: 0, par: 0, err: 0};
        tbl[5]  = '{op: 3'd5, a: 8'hC3, b: 8'hA5, y: 8'h66, zero: 0, ones: 0, par: 0, err: 0};
        tbl[6]  = '{op: 3'd6, a: 8'hC3, b: 8'hA5, y: 8'h99, zero: 0, ones: 0, par: 0, err: 0};
        tbl[7]  = '{op: 3'd3, a: 8'h00, b: 8'h00, y: 8'hFF, zero: 0, ones: 1, par: 0, err: 0};
        tbl[8]  = '{op: 3'd0, a: 8'hFF, b: 8'h0F, y: 8'h0F, zero: 0, ones: 0, par: 0, err: 0};
        tbl[9]  = '{op: 3'd7, a: 8'hFF, b: 8'h00, y: 8'h00, zero: 1, ones: 0, par: 0, err: 1};
        tbl[10] = '{op: 3'd1, a: 8'h01, b: 8'h00, y: 8'h01, zero: 0, ones: 0, par: 1, err: 0};
        tbl[11] = '{op: 3'd2, a: 8'h3C, b: 8'hFF, y: 8'h00, zero: 1, ones: 0, par: 0, err: 0};
        idle    = '{op: 3'd0, a: 8'h00, b: 8'h00, y: 8'h00, zero: 0, ones: 0, par: 0, err: 0};

        cnt_m   = '0;
        held    = 1'b0;
        chk_lat = 1'b0;

        // Reset state.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_flags", 32'({out_zero, out_ones, out_par, out_err}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors back-to-back with out_ready high; latency checked.
        chk_lat = 1'b1;
        for (int i = 0; i < 12; i++) begin
            guard = 0;
            do begin
                cycle(1'b1, tbl[i], 1'b1, acc);
                guard++;
            end while (!acc && guard < 10);
            check("table_accept", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1, acc);
        chk_lat = 1'b0;
        check("table_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: only two items fit while the consumer stalls.
        bp[0] = ref_fn(3'd0, 8'h12, 8'h34);
        bp[1] = ref_fn(3'd1, 8'h56, 8'h78);
        bp[2] = ref_fn(3'd5, 8'h9A, 8'hBC);
        bp[3] = ref_fn(3'd6, 8'hDE, 8'hF0);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(idx < 4, (idx < 4) ? bp[idx] : idle, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_frozen_y", 32'(out_y), 32'(bp[0].y));
        guard = 0;
        while ((idx < 4 || exp_q.size() > 0) && guard < 20) begin
            cycle(idx < 4, (idx < 4) ? bp[idx] : idle, 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        check("bp_all_delivered", 32'(exp_q.size()), 32'd0);

        // Illegal-op saturation: counter already at 1, five more pin it at 3.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, ref_fn(3'd7, 8'hFF, 8'(i)), 1'b1, acc);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1, acc);
        check("err_sat", 32'(err_cnt), 32'd3);

        // Reset mid-cycle with two items in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, ref_fn(3'd5, 8'(i), 8'hAA), 1'b0, acc);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        cnt_m = '0;
        held  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, idle, 1'b1, acc);
            check("no_stale_out", 32'(out_valid), 32'd0);
        end

        // Random valid/ready traffic, 1000 transfers.
        sent  = 0;
        guard = 0;
        item  = ref_fn(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        while (sent < 1000 && guard < 20000) begin
            cycle($urandom_range(0, 3) != 0, item, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                sent++;
                item = ref_fn(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            guard++;
        end
        check("rand_sent", 32'(sent), 32'd1000);
        for (int i = 0; i < 6; i++) cycle(1'b0, idle, 1'b1, acc);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
